// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall bus type, stall patterns,
// MDU state encoding and a small sizing helper.
package pipe_ctrl_pkg;

    // Stall bus: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
    typedef logic [5:0] stall_bus_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam stall_bus_t STALL_MEM  = 6'b011111;
    localparam stall_bus_t STALL_EX   = 6'b001111;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_NONE = 6'b000000;

    localparam logic [1:0] MDU_IDLE    = 2'd0;
    localparam logic [1:0] MDU_MUL_RUN = 2'd1;
    localparam logic [1:0] MDU_DIV_RUN = 2'd2;
    localparam logic [1:0] MDU_DONE    = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_ctrl_mdu_seq.sv
// Multiply/divide sequencer: start pulses, multiply countdown,
// divide ready handshake with watchdog, and the EX stall request.
// Ports: clk/rst, ex_op_mul_i, ex_op_div_i, div_ready_i, mem_wait_i,
//        mul_start_o, div_start_o, mdu_busy_o, div_timeout_o, stallreq_ex_o.
module mdu_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_MAX = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_op_mul_i,
    input  logic ex_op_div_i,
    input  logic div_ready_i,
    input  logic mem_wait_i,
    output logic mul_start_o,
    output logic div_start_o,
    output logic mdu_busy_o,
    output logic div_timeout_o,
    output logic stallreq_ex_o
);

    localparam int CW = $clog2(max_int(MUL_LAT, DIV_MAX)) + 1;
    localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_END  = CW'(DIV_MAX - 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        mul_start_o = 1'b0;
        div_start_o = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (ex_op_mul_i) begin
                    mul_start_o = 1'b1;
                    cnt_d       = MUL_INIT;
                    state_d     = MDU_MUL_RUN;
                end else if (ex_op_div_i) begin
                    div_start_o = 1'b1;
                    cnt_d       = CNT_ZERO;
                    state_d     = MDU_DIV_RUN;
                end
            end
            MDU_MUL_RUN: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = MDU_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MDU_DIV_RUN: begin
                // A real result beats the watchdog in the same cycle.
                if (div_ready_i) begin
                    state_d = MDU_DONE;
                end else if (cnt_q == DIV_END) begin
                    to_d    = 1'b1;
                    state_d = MDU_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // EX is frozen under mem_wait; hold here so the same
                // instruction is not started twice.
                if (!mem_wait_i) begin
                    state_d = MDU_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MDU_IDLE;
            cnt_q   <= CNT_ZERO;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign mdu_busy_o    = (state_q == MDU_MUL_RUN) ||
                           (state_q == MDU_DIV_RUN);
    assign stallreq_ex_o = mdu_busy_o ||
                           ((state_q == MDU_IDLE) &&
                            (ex_op_mul_i || ex_op_div_i));
    assign div_timeout_o = to_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: load-use detection and stall priority
// encoding over MEM / EX / ID requests, plus the MDU sequencer.
// Ports: clk/rst, EX/ID hazard fields, MDU op flags, div_ready,
//        mem_wait; outputs stall bus, start pulses, busy, timeout.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_MAX = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_is_load,
    input  logic       ex_we,
    input  logic [4:0] ex_waddr,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_re,
    input  logic       id_rt_re,
    input  logic       ex_op_mul,
    input  logic       ex_op_div,
    input  logic       div_ready,
    input  logic       mem_wait,
    output logic [5:0] stall,
    output logic       mul_start,
    output logic       div_start,
    output logic       mdu_busy,
    output logic       div_timeout
);

    logic lu;
    logic stallreq_ex;

    // r0 is hardwired zero, so a load to it never creates a hazard.
    assign lu = ex_is_load && ex_we && (ex_waddr != 5'd0) &&
                ((id_rs_re && (id_rs == ex_waddr)) ||
                 (id_rt_re && (id_rt == ex_waddr)));

    mdu_seq #(
        .MUL_LAT(MUL_LAT),
        .DIV_MAX(DIV_MAX)
    ) u_mdu_seq (
        .clk          (clk),
        .rst          (rst),
        .ex_op_mul_i  (ex_op_mul),
        .ex_op_div_i  (ex_op_div),
        .div_ready_i  (div_ready),
        .mem_wait_i   (mem_wait),
        .mul_start_o  (mul_start),
        .div_start_o  (div_start),
        .mdu_busy_o   (mdu_busy),
        .div_timeout_o(div_timeout),
        .stallreq_ex_o(stallreq_ex)
    );

    // Deepest stalled stage wins; STALL_ID bubbles ID into EX.
    always_comb begin
        stall = STALL_NONE;
        if (mem_wait) begin
            stall = STALL_MEM;
        end else if (stallreq_ex) begin
            stall = STALL_EX;
        end else if (lu) begin
            stall = STALL_ID;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: load-use/priority vector table
// plus directed multiply, divide, watchdog and mem_wait sequences.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_is_load, ex_we;
    logic [4:0] ex_waddr, id_rs, id_rt;
    logic       id_rs_re, id_rt_re;
    logic       ex_op_mul, ex_op_div, div_ready, mem_wait;
    logic [5:0] stall;
    logic       mul_start, div_start, mdu_busy, div_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MUL_LAT(3), .DIV_MAX(40)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_is_load (ex_is_load),
        .ex_we      (ex_we),
        .ex_waddr   (ex_waddr),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_re   (id_rs_re),
        .id_rt_re   (id_rt_re),
        .ex_op_mul  (ex_op_mul),
        .ex_op_div  (ex_op_div),
        .div_ready  (div_ready),
        .mem_wait   (mem_wait),
        .stall      (stall),
        .mul_start  (mul_start),
        .div_start  (div_start),
        .mdu_busy   (mdu_busy),
        .div_timeout(div_timeout)
    );

    typedef struct {
        logic       ld;
        logic       we;
        logic [4:0] wa;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_re;
        logic       rt_re;
        logic       mw;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Advance to the next cycle; inputs change at negedge, checks #1 later.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic clr_in();
        ex_is_load = 0; ex_we = 0; ex_waddr = 0;
        id_rs = 0; id_rt = 0; id_rs_re = 0; id_rt_re = 0;
        ex_op_mul = 0; ex_op_div = 0; div_ready = 0; mem_wait = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        nxt(); nxt();
        rst = 0;
    endtask

    initial begin
        vecs[0] = '{1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 6'b000111};
        vecs[1] = '{1, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 6'b000000};
        vecs[2] = '{1, 1, 5'd9, 5'd1, 5'd9, 1, 1, 0, 6'b000111};
        vecs[3] = '{1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 6'b000000};
        vecs[4] = '{0, 1, 5'd5, 5'd5, 5'd5, 1, 1, 0, 6'b000000};
        vecs[5] = '{1, 0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 6'b000000};
        vecs[6] = '{1, 1, 5'd7, 5'd7, 5'd0, 1, 0, 1, 6'b011111};
        vecs[7] = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 6'b011111};
        vecs[8] = '{1, 1, 5'd3, 5'd4, 5'd3, 1, 0, 0, 6'b000000};
        vecs[9] = '{1, 1, 5'd31, 5'd2, 5'd31, 0, 1, 0, 6'b000111};

        clr_in();
        rst = 1;
        nxt();
        do_reset();

        // Reset state
        #1;
        chk("rst_stall", {2'b0, stall}, 8'h00);
        chk("rst_mul_start", {7'b0, mul_start}, 8'h00);
        chk("rst_div_start", {7'b0, div_start}, 8'h00);
        chk("rst_busy", {7'b0, mdu_busy}, 8'h00);
        chk("rst_timeout", {7'b0, div_timeout}, 8'h00);

        // Load-use / mem_wait table, MDU idle
        for (int i = 0; i < 10; i++) begin
            nxt();
            ex_is_load = vecs[i].ld;  ex_we = vecs[i].we;
            ex_waddr = vecs[i].wa;    id_rs = vecs[i].rs;
            id_rt = vecs[i].rt;       id_rs_re = vecs[i].rs_re;
            id_rt_re = vecs[i].rt_re; mem_wait = vecs[i].mw;
            #1;
            chk($sformatf("vec%0d_stall", i), {2'b0, stall},
                {2'b0, vecs[i].exp});
            chk($sformatf("vec%0d_busy", i), {7'b0, mdu_busy}, 8'h00);
        end
        nxt(); clr_in();

        // Multiply: t0..t3 stalled, DONE at t4
        nxt(); ex_op_mul = 1; #1;
        chk("mul_t0_start", {7'b0, mul_start}, 8'h01);
        chk("mul_t0_stall", {2'b0, stall}, 8'h0f);
        for (int t = 1; t <= 3; t++) begin
            nxt(); #1;
            chk($sformatf("mul_t%0d_stall", t), {2'b0, stall}, 8'h0f);
            chk($sformatf("mul_t%0d_start", t), {7'b0, mul_start}, 8'h00);
            chk($sformatf("mul_t%0d_busy", t), {7'b0, mdu_busy}, 8'h01);
        end
        nxt(); #1;
        chk("mul_t4_stall", {2'b0, stall}, 8'h00);
        chk("mul_t4_busy", {7'b0, mdu_busy}, 8'h00);
        chk("mul_t4_start", {7'b0, mul_start}, 8'h00);
        nxt(); ex_op_mul = 0; #1;
        chk("mul_t5_stall", {2'b0, stall}, 8'h00);

        // Divide: div_ready at t0 ignored, real ready at t7
        nxt(); ex_op_div = 1; div_ready = 1; #1;
        chk("div_t0_start", {7'b0, div_start}, 8'h01);
        chk("div_t0_stall", {2'b0, stall}, 8'h0f);
        for (int t = 1; t <= 7; t++) begin
            nxt(); div_ready = (t == 7); #1;
            chk($sformatf("div_t%0d_stall", t), {2'b0, stall}, 8'h0f);
            chk($sformatf("div_t%0d_start", t), {7'b0, div_start}, 8'h00);
        end
        nxt(); div_ready = 0; #1;
        chk("div_t8_stall", {2'b0, stall}, 8'h00);
        chk("div_t8_busy", {7'b0, mdu_busy}, 8'h00);
        chk("div_t8_timeout", {7'b0, div_timeout}, 8'h00);
        nxt(); ex_op_div = 0;

        // Divide watchdog: released with timeout at t41
        nxt(); ex_op_div = 1; #1;
        chk("wd_t0_start", {7'b0, div_start}, 8'h01);
        for (int t = 1; t <= 40; t++) begin
            nxt(); #1;
            chk($sformatf("wd_t%0d_stall", t), {2'b0, stall}, 8'h0f);
            chk($sformatf("wd_t%0d_to", t), {7'b0, div_timeout}, 8'h00);
        end
        nxt(); #1;
        chk("wd_t41_stall", {2'b0, stall}, 8'h00);
        chk("wd_t41_timeout", {7'b0, div_timeout}, 8'h01);
        nxt(); ex_op_div = 0; #1;
        chk("wd_t42_sticky", {7'b0, div_timeout}, 8'h01);
        nxt(); nxt(); #1;
        chk("wd_t44_sticky", {7'b0, div_timeout}, 8'h01);
        do_reset(); #1;
        chk("wd_rst_clear", {7'b0, div_timeout}, 8'h00);

        // Multiply reaches DONE under mem_wait for 3 cycles
        nxt(); ex_op_mul = 1; #1;
        chk("mw_t0_start", {7'b0, mul_start}, 8'h01);
        nxt(); nxt(); nxt();
        for (int t = 4; t <= 6; t++) begin
            nxt(); mem_wait = 1; #1;
            chk($sformatf("mw_t%0d_stall", t), {2'b0, stall}, 8'h1f);
            chk($sformatf("mw_t%0d_start", t), {7'b0, mul_start}, 8'h00);
        end
        nxt(); mem_wait = 0; #1;
        chk("mw_t7_stall", {2'b0, stall}, 8'h00);
        chk("mw_t7_start", {7'b0, mul_start}, 8'h00);
        nxt(); ex_op_mul = 0; #1;
        chk("mw_t8_stall", {2'b0, stall}, 8'h00);
        chk("mw_t8_busy", {7'b0, mdu_busy}, 8'h00);

        // lu + mul (+div) + mem_wait: mem wins, mul has start priority
        nxt();
        ex_is_load = 1; ex_we = 1; ex_waddr = 5'd6;
        id_rs = 5'd6; id_rs_re = 1;
        ex_op_mul = 1; ex_op_div = 1; mem_wait = 1; #1;
        chk("pri_t0_stall", {2'b0, stall}, 8'h1f);
        chk("pri_t0_mul", {7'b0, mul_start}, 8'h01);
        chk("pri_t0_div", {7'b0, div_start}, 8'h00);
        nxt(); mem_wait = 0; #1;
        chk("pri_t1_stall", {2'b0, stall}, 8'h0f);
        nxt(); nxt(); nxt(); #1;
        chk("pri_t4_lu", {2'b0, stall}, 8'h07);
        nxt(); clr_in();
        nxt();

        // Reset mid-divide
        nxt(); ex_op_div = 1;
        nxt(); nxt(); ex_op_div = 0; rst = 1;
        nxt(); rst = 0; #1;
        chk("rmid_busy", {7'b0, mdu_busy}, 8'h00);
        chk("rmid_stall", {2'b0, stall}, 8'h00);
        chk("rmid_div", {7'b0, div_start}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
